// File: rtl/ft_alu_seq.sv
// ft_alu_seq: fault-tolerant add/subtract sequencer.
// The operation runs on two independent ripple-carry copies and is checked by
// sum-parity prediction. A mismatch causes the operation to be re-executed,
// up to RETRY_MAX times. Illegal input codewords and non-one-hot controls are
// reported as errors straight away, without any retry.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// EXEC  | one attempt per cycle; retry while checks fail and budget left
// DONE  | result held, out_valid=1 until out_ready
module ft_alu_seq #(
    parameter int W         = 3,
    parameter int RETRY_MAX = 2,
    parameter int ECNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      A,
    input  logic [W-1:0]      B,
    input  logic              PAR,
    input  logic [2:0]        C,
    input  logic [W:0]        INJ,
    input  logic              INJ_PERSIST,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      X,
    output logic              XC,
    output logic [1:0]        XE,
    output logic              RETRIED,
    output logic [ECNT_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] RMAX    = 3'(RETRY_MAX);
    localparam logic [1:0] XE_GOOD = 2'b10;
    localparam logic [1:0] XE_ERR  = 2'b11;

    state_t state, state_nxt;

    logic [W-1:0] a_r, b_r;
    logic         par_r;
    logic [2:0]   c_r;
    logic [W:0]   inj_r;
    logic         inj_persist_r;
    logic [2:0]   attempt;

    logic [W-1:0] post_a, post_b;
    logic [W:0]   res_p, res_s, res_pm, inj_mask;
    logic         carry_par_p;
    logic         pred_par, lc_err, cmp_err, c_onehot, in_err, exec_err, retry_ok;

    // Operand conditioning: two's-complement negate selected by the control.
    always_comb begin
        post_a = c_r[2] ? (~a_r + W'(1)) : a_r;
        post_b = c_r[1] ? (~b_r + W'(1)) : b_r;
    end

    // Primary ripple-carry copy; also yields parity of its internal carries.
    always_comb begin : copy_primary
        logic [W:0]   cy;
        logic [W-1:0] sm;
        cy = '0;
        sm = '0;
        for (int i = 0; i < W; i++) begin
            sm[i]   = post_a[i] ^ post_b[i] ^ cy[i];
            cy[i+1] = (post_a[i] & post_b[i]) | (cy[i] & (post_a[i] ^ post_b[i]));
        end
        res_p       = {cy[W], sm};
        carry_par_p = ^cy[W-1:0];
    end

    // Shadow ripple-carry copy used only for the duplicate compare.
    always_comb begin : copy_shadow
        logic [W:0]   cy;
        logic [W-1:0] sm;
        cy = '0;
        sm = '0;
        for (int i = 0; i < W; i++) begin
            sm[i]   = post_a[i] ^ post_b[i] ^ cy[i];
            cy[i+1] = (post_a[i] & post_b[i]) | (cy[i] & (post_a[i] ^ post_b[i]));
        end
        res_s = {cy[W], sm};
    end

    // Fault injection on the primary copy and all error checks.
    always_comb begin
        inj_mask = (inj_persist_r || (attempt == 3'd0)) ? inj_r : '0;
        res_pm   = res_p ^ inj_mask;
        pred_par = (^post_a) ^ (^post_b) ^ carry_par_p;
        lc_err   = pred_par != (^res_pm[W-1:0]);
        cmp_err  = res_pm != res_s;
        c_onehot = (c_r == 3'b001) || (c_r == 3'b010) || (c_r == 3'b100);
        in_err   = !(^{a_r, b_r, par_r}) || !c_onehot;
        exec_err = cmp_err || lc_err;
        retry_ok = attempt != RMAX;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = S_EXEC;
            S_EXEC: begin
                if (in_err)                    state_nxt = S_DONE;
                else if (exec_err && retry_ok) state_nxt = S_EXEC;
                else                           state_nxt = S_DONE;
            end
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Operand capture, attempt tracking and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r           <= '0;
            b_r           <= '0;
            par_r         <= 1'b0;
            c_r           <= '0;
            inj_r         <= '0;
            inj_persist_r <= 1'b0;
            attempt       <= '0;
            X             <= '0;
            XC            <= 1'b0;
            XE            <= XE_ERR;
            RETRIED       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r           <= A;
                        b_r           <= B;
                        par_r         <= PAR;
                        c_r           <= C;
                        inj_r         <= INJ;
                        inj_persist_r <= INJ_PERSIST;
                        attempt       <= '0;
                        RETRIED       <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (!in_err && exec_err && retry_ok) begin
                        attempt <= attempt + 3'd1;
                        RETRIED <= 1'b1;
                    end else begin
                        X  <= res_pm[W-1:0];
                        XC <= res_pm[W];
                        XE <= (in_err || exec_err) ? XE_ERR : XE_GOOD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating count of error results actually handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ERR_CNT <= '0;
        end else if (out_valid && out_ready && (XE == XE_ERR) && (ERR_CNT != '1)) begin
            ERR_CNT <= ERR_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_ft_alu_seq.sv
// Directed table-driven bench for ft_alu_seq (W=3, RETRY_MAX=2, ECNT_W=3).
module tb_ft_alu_seq;
    localparam int W  = 3;
    localparam int RM = 2;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0, B = '0;
    logic          PAR = 1'b0;
    logic [2:0]    C = '0;
    logic [W:0]    INJ = '0;
    logic          INJ_PERSIST = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  X;
    logic          XC;
    logic [1:0]    XE;
    logic          RETRIED;
    logic [EW-1:0] ERR_CNT;

    always #5 clk = ~clk;

    ft_alu_seq #(.W(W), .RETRY_MAX(RM), .ECNT_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .PAR(PAR), .C(C), .INJ(INJ), .INJ_PERSIST(INJ_PERSIST),
        .out_valid(out_valid), .out_ready(out_ready), .X(X), .XC(XC), .XE(XE),
        .RETRIED(RETRIED), .ERR_CNT(ERR_CNT)
    );

    typedef struct {
        logic [2:0] a, b, c;
        logic [3:0] inj;
        logic       pers, badp, chkx;
        logic [2:0] x;
        logic       xc;
        logic [1:0] xe;
        logic       r;
        int         lat;
    } vec_t;

    vec_t tv[13];
    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " X"}, int'(X), 0);
        chk({tag, " XC"}, int'(XC), 0);
        chk({tag, " XE"}, int'(XE), 3);
        chk({tag, " RETRIED"}, int'(RETRIED), 0);
        chk({tag, " ERR_CNT"}, int'(ERR_CNT), 0);
    endtask

    // Called at a negedge; returns at a negedge after the result handshake.
    task automatic run_op(input vec_t v, input int hold, input int idx);
        int lat;
        string t;
        t = $sformatf("v%0d", idx);
        chk({t, " in_ready"}, int'(in_ready), 1);
        A = v.a; B = v.b; C = v.c; INJ = v.inj; INJ_PERSIST = v.pers;
        PAR = ~((^v.a) ^ (^v.b)) ^ v.badp;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = ~v.a; B = ~v.b; INJ = '0; PAR = ~PAR;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk({t, " latency"}, lat, v.lat);
        if (v.chkx) begin
            chk({t, " X"}, int'(X), int'(v.x));
            chk({t, " XC"}, int'(XC), int'(v.xc));
        end
        chk({t, " XE"}, int'(XE), int'(v.xe));
        chk({t, " RETRIED"}, int'(RETRIED), int'(v.r));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({t, " hold out_valid"}, int'(out_valid), 1);
            chk({t, " hold X"}, int'(X), int'(v.x));
            chk({t, " hold XC"}, int'(XC), int'(v.xc));
            chk({t, " hold XE"}, int'(XE), int'(v.xe));
            chk({t, " hold RETRIED"}, int'(RETRIED), int'(v.r));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (v.xe == 2'b11 && exp_cnt < 7) exp_cnt++;
        @(negedge clk);
        chk({t, " ERR_CNT"}, int'(ERR_CNT), exp_cnt);
        chk({t, " post out_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        //         a     b     c       inj    pers  badp  chkx  x     xc    xe     r     lat
        tv[0]  = '{3'd3, 3'd2, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 2'b10, 1'b0, 2};
        tv[1]  = '{3'd2, 3'd5, 3'b010, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 2'b10, 1'b0, 2};
        tv[2]  = '{3'd2, 3'd5, 3'b100, 4'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 2'b10, 1'b0, 2};
        tv[3]  = '{3'd3, 3'd2, 3'b001, 4'h0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 2'b11, 1'b0, 2};
        tv[4]  = '{3'd3, 3'd2, 3'b011, 4'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 2'b11, 1'b0, 2};
        tv[5]  = '{3'd1, 3'd1, 3'b000, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 2'b11, 1'b0, 2};
        tv[6]  = '{3'd3, 3'd2, 3'b001, 4'h1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 2'b10, 1'b1, 3};
        tv[7]  = '{3'd3, 3'd2, 3'b001, 4'h1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'b11, 1'b1, 4};
        tv[8]  = '{3'd1, 3'd1, 3'b001, 4'h8, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'b11, 1'b1, 4};
        tv[9]  = '{3'd7, 3'd7, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 2'b10, 1'b0, 2};
        tv[10] = '{3'd0, 3'd0, 3'b010, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'b10, 1'b0, 2};
        tv[11] = '{3'd0, 3'd3, 3'b010, 4'h0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 2'b10, 1'b0, 2};
        tv[12] = '{3'd7, 3'd0, 3'b001, 4'h4, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 2'b10, 1'b1, 3};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_op(tv[i], 0, i);

        // Consumer stall: result must hold for 5 cycles.
        run_op(tv[2], 5, 100);

        // Error counter saturation at 7 (5 errors so far).
        for (int k = 0; k < 3; k++) run_op(tv[3], 0, 200 + k);

        // Reset mid-EXEC discards the in-flight result.
        A = tv[7].a; B = tv[7].b; C = tv[7].c; INJ = tv[7].inj; INJ_PERSIST = 1'b1;
        PAR = ~((^tv[7].a) ^ (^tv[7].b));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid-exec out_valid", int'(out_valid), 0);
        chk("mid-exec in_ready", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post-reset out_valid", int'(out_valid), 0);
        end

        // First accept right on the first edge after reset release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(tv[0], 0, 300);
        run_op(tv[4], 0, 301);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
